// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and the multicycle mult/div unit. Pipeline writes win by default;
// mult/div results queue in a small FIFO and drain on idle port cycles. A head
// that has waited too long forces a one-cycle pipeline stall so it can drain.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   wb_we/wb_rd/wb_data     pipeline writeback request
//   md_valid/md_rd/md_data  mult/div result (held until md_ready)
//   md_exc/md_exc_code      mult/div exception; redirected to the status register
//   md_ready                FIFO can accept a result this cycle
//   stall_pipe              freeze pipeline writeback/upstream (state decode only)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  regfile write port
//   pending_mask            one-hot OR of rd over live FIFO entries
module writeback_port_arbiter #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned RSTATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_exc,
  input  logic [2:0]  md_exc_code,
  output logic        md_ready,
  output logic        stall_pipe,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] pending_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AGE_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [AGE_W-1:0]   age_q, age_d;

  logic   push, pop, wb_sel, head_sel, head_live, head_dead, force_cond;
  entry_t push_entry;

  // Forced drain is purely a state decode, so no input reaches stall_pipe.
  assign stall_pipe = (state_q == FORCE);
  assign md_ready   = (count_q < CNT_W'(DEPTH));

  // Push formation: exceptions redirect into the status register; r0 results vanish.
  always_comb begin
    push_entry = '0;
    if (md_exc) begin
      push_entry.rd   = 5'(RSTATUS_REG);
      push_entry.data = {29'b0, md_exc_code};
    end else begin
      push_entry.rd   = md_rd;
      push_entry.data = md_data;
    end
    push = md_valid && md_ready && (md_exc || (md_rd != 5'd0));
  end

  // Port select and pop decision. A killed head pops without touching the port.
  always_comb begin
    head_live = (count_q != '0) && live_q[rd_ptr_q];
    head_dead = (count_q != '0) && !live_q[rd_ptr_q];
    // reset_n gates the pipeline path so the port reads idle while held in reset.
    wb_sel    = reset_n && !stall_pipe && wb_we && (wb_rd != 5'd0);
    head_sel  = !wb_sel && head_live;
    pop       = head_sel || head_dead;

    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (wb_sel) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = wb_rd;
      data_writeReg    = wb_data;
    end else if (head_sel) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = mem_q[rd_ptr_q].rd;
      data_writeReg    = mem_q[rd_ptr_q].data;
    end
  end

  // Live bits: pop clears the head, a pipeline write kills same-rd entries (WAW),
  // then the push marks the new tail live.
  always_comb begin
    live_d = live_q;
    if (pop) live_d[rd_ptr_q] = 1'b0;
    if (wb_sel) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == wb_rd) live_d[i] = 1'b0;
      end
    end
    if (push) live_d[wr_ptr_q] = 1'b1;
  end

  // Occupancy and head age.
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    age_d = age_q;
    if ((count_q == '0) || pop) begin
      age_d = '0;
    end else if (age_q != AGE_W'(MAX_WAIT - 1)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Next state.
  always_comb begin
    state_d    = state_q;
    force_cond = (head_live && !pop && (age_q == AGE_W'(MAX_WAIT - 1))) ||
                 ((count_q == CNT_W'(DEPTH)) && md_valid);
    case (state_q)
      IDLE:    if (count_d != '0) state_d = PEND;
      PEND: begin
        if (count_d == '0)    state_d = IDLE;
        else if (force_cond)  state_d = FORCE;
      end
      FORCE:   state_d = (count_d != '0) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode interlock: destinations still owed by live FIFO entries.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask[mem_q[i].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // State, pointers and storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      live_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      age_q   <= age_d;
      live_q  <= live_d;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed bench for writeback_port_arbiter (DEPTH=2, MAX_WAIT=4, RSTATUS_REG=30).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_writeback_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exc;
  logic [2:0]  md_exc_code;
  logic        md_ready;
  logic        stall_pipe;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  writeback_port_arbiter #(.DEPTH(2), .MAX_WAIT(4), .RSTATUS_REG(30)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_exc           (md_exc),
    .md_exc_code      (md_exc_code),
    .md_ready         (md_ready),
    .stall_pipe       (stall_pipe),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pending_mask     (pending_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Port check packs {we, reg, data} into one comparison.
  task automatic chk_port(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    chk(tag, 64'({ctrl_writeEnable, ctrl_writeReg, data_writeReg}), 64'({we, rd, data}));
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we = we; wb_rd = rd; wb_data = data;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] data,
                          input logic exc, input logic [2:0] code);
    md_valid = v; md_rd = rd; md_data = data; md_exc = exc; md_exc_code = code;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    #3;
    chk("rst_ready", 64'(md_ready), 64'd1);
    chk("rst_stall", 64'(stall_pipe), 64'd0);
    chk_port("rst_port", 1'b0, 5'd0, 32'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: basic push then drain on the following idle port cycle
    drive_md(1'b1, 5'd5, 32'h1234, 1'b0, 3'd0);
    sample();
    chk_port("t1_push_cycle_port", 1'b0, 5'd0, 32'd0);
    chk("t1_push_cycle_mask", 64'(pending_mask), 64'd0);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    sample();
    chk_port("t1_drain_port", 1'b1, 5'd5, 32'h1234);
    chk("t1_drain_mask", 64'(pending_mask), 64'h20);
    tick();
    sample();
    chk_port("t1_after_port", 1'b0, 5'd0, 32'd0);
    chk("t1_after_mask", 64'(pending_mask), 64'd0);
    tick();

    // 2: age-forced drain under continuous pipeline writes to r3
    drive_md(1'b1, 5'd7, 32'h77, 1'b0, 3'd0);
    drive_wb(1'b1, 5'd3, 32'h33);
    sample();
    chk_port("t2_c0_port", 1'b1, 5'd3, 32'h33);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk_port($sformatf("t2_wait%0d_port", c), 1'b1, 5'd3, 32'h33);
      chk($sformatf("t2_wait%0d_stall", c), 64'(stall_pipe), 64'd0);
      tick();
    end
    sample();
    chk("t2_force_stall", 64'(stall_pipe), 64'd1);
    chk_port("t2_force_port", 1'b1, 5'd7, 32'h77);
    chk("t2_force_mask", 64'(pending_mask), 64'h80);
    tick();
    sample();
    chk("t2_post_stall", 64'(stall_pipe), 64'd0);
    chk_port("t2_post_port", 1'b1, 5'd3, 32'h33);
    chk("t2_post_mask", 64'(pending_mask), 64'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);

    // 3: WAW kill of a queued r9 result by a pipeline write to r9
    drive_md(1'b1, 5'd9, 32'h99, 1'b0, 3'd0);
    sample();
    chk_port("t3_push_port", 1'b0, 5'd0, 32'd0);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    drive_wb(1'b1, 5'd9, 32'hAA);
    sample();
    chk_port("t3_wb_port", 1'b1, 5'd9, 32'hAA);
    chk("t3_wb_mask", 64'(pending_mask), 64'h200);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    sample();
    chk_port("t3_silent_pop_port", 1'b0, 5'd0, 32'd0);
    chk("t3_silent_pop_mask", 64'(pending_mask), 64'd0);
    tick();
    sample();
    chk_port("t3_after_port", 1'b0, 5'd0, 32'd0);
    chk("t3_after_ready", 64'(md_ready), 64'd1);
    tick();

    // 4: exception redirected to r30 with zero-extended code
    drive_md(1'b1, 5'd12, 32'hDEAD_BEEF, 1'b1, 3'd3);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    sample();
    chk_port("t4_exc_port", 1'b1, 5'd30, 32'h3);
    chk("t4_exc_mask", 64'(pending_mask), 64'h4000_0000);
    tick();

    // 5: fill the FIFO under wb traffic with md_valid held -> forced drain
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_md(1'b1, 5'd10, 32'hA0, 1'b0, 3'd0);
    sample();
    chk("t5_c0_ready", 64'(md_ready), 64'd1);
    tick();
    drive_md(1'b1, 5'd11, 32'hB0, 1'b0, 3'd0);
    sample();
    chk("t5_c1_ready", 64'(md_ready), 64'd1);
    tick();
    drive_md(1'b1, 5'd12, 32'hC0, 1'b0, 3'd0);
    sample();
    chk("t5_full_ready", 64'(md_ready), 64'd0);
    chk("t5_full_stall", 64'(stall_pipe), 64'd0);
    chk("t5_full_mask", 64'(pending_mask), 64'hC00);
    chk_port("t5_full_port", 1'b1, 5'd3, 32'h33);
    tick();
    sample();
    chk("t5_force_stall", 64'(stall_pipe), 64'd1);
    chk("t5_force_ready", 64'(md_ready), 64'd0);
    chk_port("t5_force_port", 1'b1, 5'd10, 32'hA0);
    tick();
    sample();
    chk("t5_third_ready", 64'(md_ready), 64'd1);
    chk("t5_third_stall", 64'(stall_pipe), 64'd0);
    chk_port("t5_third_port", 1'b1, 5'd3, 32'h33);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    sample();
    chk("t5_drain1_mask", 64'(pending_mask), 64'h1800);
    chk_port("t5_drain1_port", 1'b1, 5'd11, 32'hB0);
    tick();
    sample();
    chk_port("t5_drain2_port", 1'b1, 5'd12, 32'hC0);
    tick();
    sample();
    chk_port("t5_empty_port", 1'b0, 5'd0, 32'd0);
    chk("t5_empty_mask", 64'(pending_mask), 64'd0);
    tick();

    // 6: reset with two entries pending discards them
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_md(1'b1, 5'd13, 32'hD0, 1'b0, 3'd0);
    tick();
    drive_md(1'b1, 5'd14, 32'hE0, 1'b0, 3'd0);
    tick();
    drive_md(1'b0, 5'd0, 32'd0, 1'b0, 3'd0);
    sample();
    chk("t6_pending_mask", 64'(pending_mask), 64'h6000);
    #1;
    reset_n = 1'b0;
    #1;
    chk_port("t6_rst_port", 1'b0, 5'd0, 32'd0);
    chk("t6_rst_mask", 64'(pending_mask), 64'd0);
    chk("t6_rst_ready", 64'(md_ready), 64'd1);
    chk("t6_rst_stall", 64'(stall_pipe), 64'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk_port($sformatf("t6_post%0d_port", c), 1'b0, 5'd0, 32'd0);
      chk($sformatf("t6_post%0d_mask", c), 64'(pending_mask), 64'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
